mouse_click_conditioner: RTL and testbench

- Upstream input stage for the CAPTCHA3 animation pipeline. Sits between the PS/2 mouse controller and the animation stages that consume mouse_left, mouse_x and mouse_y.
- Turns the raw button and 12-bit coordinates into a clamped 96x64 cursor, debounced single-cycle click and release pulses, a latched click position, and a drag indication.
- Guarantees that a button already held when the captcha starts never registers as a click.

---
 rtl/mouse_click_conditioner.sv | 166 ++++++++++++++++
 tb/tb_mouse_click_conditioner.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mouse_click_conditioner.sv
// Mouse input conditioner: clamps raw coordinates to the cursor area, debounces the
// left button and turns press/release into click, release, tap and drag indications.
module mouse_click_conditioner #(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int SCALE_SHIFT     = 0,
   parameter int X_MAX           = 95,
   parameter int Y_MAX           = 63,
   parameter int DRAG_THRESHOLD  = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        enable_i,
   input  logic        mouse_left_i,
   input  logic [11:0] mouse_x_i,
   input  logic [11:0] mouse_y_i,
   output logic [6:0]  cursor_x_o,
   output logic [6:0]  cursor_y_o,
   output logic        click_pulse_o,
   output logic        release_pulse_o,
   output logic [6:0]  click_x_o,
   output logic [6:0]  click_y_o,
   output logic        held_o,
   output logic        drag_active_o,
   output logic        tap_o
);

   localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [11:0]    X_LIM    = 12'(X_MAX);
   localparam logic [11:0]    Y_LIM    = 12'(Y_MAX);
   localparam logic [6:0]     DRAG_LIM = 7'(DRAG_THRESHOLD);

   typedef enum logic [1:0] {WAIT_RELEASE, IDLE, PRESSED, DRAGGING} state_t;

   logic [11:0]   sx, sy;
   logic [6:0]    cursor_x_d, cursor_y_d, cursor_x_q, cursor_y_q;
   logic [1:0]    sync_q;
   logic          s;
   logic [CW-1:0] cnt_d, cnt_q;
   logic          db_d, db_q;
   logic          rise_d, fall_d, rise_q, fall_q;
   state_t        state_d, state_q;
   logic          click_pulse_d, click_pulse_q;
   logic          release_pulse_d, release_pulse_q;
   logic          tap_d, tap_q;
   logic [6:0]    click_x_d, click_y_d, click_x_q, click_y_q;
   logic          held_d, held_q, drag_d, drag_q;
   logic [6:0]    dx, dy;
   logic          far;

   assign sx         = mouse_x_i >> SCALE_SHIFT;
   assign sy         = mouse_y_i >> SCALE_SHIFT;
   assign cursor_x_d = (sx > X_LIM) ? X_LIM[6:0] : sx[6:0];
   assign cursor_y_d = (sy > Y_LIM) ? Y_LIM[6:0] : sy[6:0];
   assign s          = sync_q[1];

   // A level change is accepted only after it has been seen on DEBOUNCE_CYCLES consecutive samples.
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (s != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d = ~db_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign rise_d = db_d & ~db_q;
   assign fall_d = ~db_d & db_q;

   assign dx  = (cursor_x_q >= click_x_q) ? (cursor_x_q - click_x_q) : (click_x_q - cursor_x_q);
   assign dy  = (cursor_y_q >= click_y_q) ? (cursor_y_q - click_y_q) : (click_y_q - cursor_y_q);
   assign far = (dx > DRAG_LIM) || (dy > DRAG_LIM);

   always_comb begin
      state_d         = state_q;
      click_pulse_d   = 1'b0;
      release_pulse_d = 1'b0;
      tap_d           = 1'b0;
      click_x_d       = click_x_q;
      click_y_d       = click_y_q;
      if (!enable_i) begin
         state_d = WAIT_RELEASE;
      end else begin
         case (state_q)
            WAIT_RELEASE: if (!db_q) state_d = IDLE;
            IDLE: begin
               if (rise_q) begin
                  state_d       = PRESSED;
                  click_pulse_d = 1'b1;
                  click_x_d     = cursor_x_q;
                  click_y_d     = cursor_y_q;
               end
            end
            // A release always beats the drag check in the same cycle.
            PRESSED: begin
               if (fall_q) begin
                  state_d         = IDLE;
                  release_pulse_d = 1'b1;
                  tap_d           = 1'b1;
               end else if (far) begin
                  state_d = DRAGGING;
               end
            end
            DRAGGING: begin
               if (fall_q) begin
                  state_d         = IDLE;
                  release_pulse_d = 1'b1;
               end
            end
            default: state_d = WAIT_RELEASE;
         endcase
      end
      held_d = (state_d == PRESSED) || (state_d == DRAGGING);
      drag_d = (state_d == DRAGGING);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cursor_x_q      <= '0;
         cursor_y_q      <= '0;
         sync_q          <= '0;
         cnt_q           <= '0;
         db_q            <= 1'b0;
         rise_q          <= 1'b0;
         fall_q          <= 1'b0;
         state_q         <= WAIT_RELEASE;
         click_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         tap_q           <= 1'b0;
         click_x_q       <= '0;
         click_y_q       <= '0;
         held_q          <= 1'b0;
         drag_q          <= 1'b0;
      end else begin
         cursor_x_q      <= cursor_x_d;
         cursor_y_q      <= cursor_y_d;
         sync_q          <= {sync_q[0], mouse_left_i};
         cnt_q           <= cnt_d;
         db_q            <= db_d;
         rise_q          <= rise_d;
         fall_q          <= fall_d;
         state_q         <= state_d;
         click_pulse_q   <= click_pulse_d;
         release_pulse_q <= release_pulse_d;
         tap_q           <= tap_d;
         click_x_q       <= click_x_d;
         click_y_q       <= click_y_d;
         held_q          <= held_d;
         drag_q          <= drag_d;
      end
   end

   assign cursor_x_o      = cursor_x_q;
   assign cursor_y_o      = cursor_y_q;
   assign click_pulse_o   = click_pulse_q;
   assign release_pulse_o = release_pulse_q;
   assign tap_o           = tap_q;
   assign click_x_o       = click_x_q;
   assign click_y_o       = click_y_q;
   assign held_o          = held_q;
   assign drag_active_o   = drag_q;

endmodule

// File: tb/tb_mouse_click_conditioner.sv
// Directed bench for mouse_click_conditioner with a 4-cycle debounce window.
module tb_mouse_click_conditioner;

   logic        clk = 1'b0;
   logic        rst_n, enable, mouse_left;
   logic [11:0] mouse_x, mouse_y;
   logic [6:0]  cursor_x, cursor_y, click_x, click_y;
   logic        click_pulse, release_pulse, held, drag_active, tap;

   int errors = 0;
   int checks = 0;
   int clicks, rels, taps, click_at;

   always #5 clk = ~clk;

   mouse_click_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .mouse_left_i(mouse_left),
      .mouse_x_i(mouse_x), .mouse_y_i(mouse_y),
      .cursor_x_o(cursor_x), .cursor_y_o(cursor_y),
      .click_pulse_o(click_pulse), .release_pulse_o(release_pulse),
      .click_x_o(click_x), .click_y_o(click_y),
      .held_o(held), .drag_active_o(drag_active), .tap_o(tap)
   );

   // Steps n cycles, sampling at each falling edge, and tallies the pulse outputs.
   task automatic run_cycles(input int n, output int c, output int r, output int t, output int first);
      c = 0; r = 0; t = 0; first = -1;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (click_pulse) begin
            c++;
            if (first < 0) first = k;
         end
         if (release_pulse) r++;
         if (release_pulse && tap) t++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1; mouse_left = 1'b0; mouse_x = 12'd50; mouse_y = 12'd20;
      repeat (3) @(negedge clk);
      checks++; if (cursor_x !== 7'd0) begin errors++; $display("FAIL reset_cursor_x got %0d want 0", cursor_x); end
      checks++; if ({click_pulse, release_pulse, held, drag_active, tap} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got %b want 00000", {click_pulse, release_pulse, held, drag_active, tap}); end
      checks++; if ({click_x, click_y} !== 14'd0) begin errors++; $display("FAIL reset_click_xy got %0d,%0d want 0,0", click_x, click_y); end
      rst_n = 1'b1;
      mouse_x = 12'd40; mouse_y = 12'd30;
      run_cycles(3, clicks, rels, taps, click_at);
      checks++; if (cursor_x !== 7'd40 || cursor_y !== 7'd30) begin
         errors++; $display("FAIL cursor_follow got %0d,%0d want 40,30", cursor_x, cursor_y); end
   endtask

   task automatic test_click_latency();
      mouse_left = 1'b1;
      run_cycles(10, clicks, rels, taps, click_at);
      checks++; if (clicks !== 1) begin errors++; $display("FAIL click_count got %0d want 1", clicks); end
      checks++; if (click_at !== 7) begin errors++; $display("FAIL click_latency got %0d want 7", click_at); end
      checks++; if (held !== 1'b1 || drag_active !== 1'b0) begin
         errors++; $display("FAIL held_after_click got held=%b drag=%b want 1,0", held, drag_active); end
   endtask

   task automatic test_tap_release();
      checks++; if (click_x !== 7'd40 || click_y !== 7'd30) begin
         errors++; $display("FAIL click_latch got %0d,%0d want 40,30", click_x, click_y); end
      mouse_left = 1'b0;
      run_cycles(10, clicks, rels, taps, click_at);
      checks++; if (rels !== 1 || taps !== 1) begin
         errors++; $display("FAIL tap_release got rel=%0d tap=%0d want 1,1", rels, taps); end
      checks++; if (held !== 1'b0 || tap !== 1'b0) begin
         errors++; $display("FAIL after_tap got held=%b tap=%b want 0,0", held, tap); end
   endtask

   task automatic test_drag();
      mouse_x = 12'd10;
      run_cycles(3, clicks, rels, taps, click_at);
      mouse_left = 1'b1;
      run_cycles(10, clicks, rels, taps, click_at);
      checks++; if (clicks !== 1 || click_x !== 7'd10) begin
         errors++; $display("FAIL drag_click got clicks=%0d x=%0d want 1,10", clicks, click_x); end
      mouse_x = 12'd11;
      run_cycles(3, clicks, rels, taps, click_at);
      checks++; if (drag_active !== 1'b0) begin errors++; $display("FAIL drag_d1 got %b want 0", drag_active); end
      mouse_x = 12'd12;
      run_cycles(3, clicks, rels, taps, click_at);
      checks++; if (drag_active !== 1'b0 || held !== 1'b1) begin
         errors++; $display("FAIL drag_d2 got drag=%b held=%b want 0,1", drag_active, held); end
      mouse_x = 12'd13;
      run_cycles(3, clicks, rels, taps, click_at);
      checks++; if (drag_active !== 1'b1 || held !== 1'b1) begin
         errors++; $display("FAIL drag_d3 got drag=%b held=%b want 1,1", drag_active, held); end
      mouse_left = 1'b0;
      run_cycles(10, clicks, rels, taps, click_at);
      checks++; if (rels !== 1 || taps !== 0) begin
         errors++; $display("FAIL drag_release got rel=%0d tap=%0d want 1,0", rels, taps); end
      checks++; if (drag_active !== 1'b0 || held !== 1'b0) begin
         errors++; $display("FAIL drag_end got drag=%b held=%b want 0,0", drag_active, held); end
   endtask

   task automatic test_glitch_and_clamp();
      clicks = 0;
      for (int g = 0; g < 3; g++) begin
         int c, r, t, f;
         mouse_left = 1'b1;
         run_cycles(3, c, r, t, f);
         clicks += c + r;
         mouse_left = 1'b0;
         run_cycles(3, c, r, t, f);
         clicks += c + r;
      end
      run_cycles(8, click_at, rels, taps, click_at);
      checks++; if (clicks + rels !== 0 || held !== 1'b0) begin
         errors++; $display("FAIL glitch got pulses=%0d held=%b want 0,0", clicks + rels, held); end
      mouse_x = 12'hFFF; mouse_y = 12'd200;
      run_cycles(2, clicks, rels, taps, click_at);
      checks++; if (cursor_x !== 7'd95 || cursor_y !== 7'd63) begin
         errors++; $display("FAIL clamp_high got %0d,%0d want 95,63", cursor_x, cursor_y); end
      mouse_x = 12'd96; mouse_y = 12'd63;
      run_cycles(2, clicks, rels, taps, click_at);
      checks++; if (cursor_x !== 7'd95 || cursor_y !== 7'd63) begin
         errors++; $display("FAIL clamp_edge got %0d,%0d want 95,63", cursor_x, cursor_y); end
      mouse_x = 12'd94; mouse_y = 12'd64;
      run_cycles(2, clicks, rels, taps, click_at);
      checks++; if (cursor_x !== 7'd94 || cursor_y !== 7'd63) begin
         errors++; $display("FAIL clamp_inside got %0d,%0d want 94,63", cursor_x, cursor_y); end
   endtask

   task automatic test_enable_drop();
      mouse_x = 12'd10; mouse_y = 12'd30;
      run_cycles(3, clicks, rels, taps, click_at);
      mouse_left = 1'b1;
      run_cycles(10, clicks, rels, taps, click_at);
      mouse_x = 12'd20;
      run_cycles(3, clicks, rels, taps, click_at);
      checks++; if (drag_active !== 1'b1) begin errors++; $display("FAIL en_drag got %b want 1", drag_active); end
      enable = 1'b0;
      run_cycles(1, clicks, rels, taps, click_at);
      enable = 1'b1;
      checks++; if (held !== 1'b0 || drag_active !== 1'b0 || rels !== 0) begin
         errors++; $display("FAIL en_drop got held=%b drag=%b rel=%0d want 0,0,0", held, drag_active, rels); end
      checks++; if (click_x !== 7'd10) begin errors++; $display("FAIL en_click_x got %0d want 10", click_x); end
      run_cycles(10, clicks, rels, taps, click_at);
      checks++; if (clicks !== 0 || held !== 1'b0) begin
         errors++; $display("FAIL en_still_held got clicks=%0d held=%b want 0,0", clicks, held); end
      mouse_left = 1'b0;
      run_cycles(10, clicks, rels, taps, click_at);
      checks++; if (rels !== 0) begin errors++; $display("FAIL en_release got %0d want 0", rels); end
      mouse_left = 1'b1;
      run_cycles(10, clicks, rels, taps, click_at);
      checks++; if (clicks !== 1 || click_x !== 7'd20) begin
         errors++; $display("FAIL en_reclick got clicks=%0d x=%0d want 1,20", clicks, click_x); end
      mouse_left = 1'b0;
      run_cycles(10, clicks, rels, taps, click_at);
   endtask

   task automatic test_held_at_start();
      rst_n = 1'b0; enable = 1'b0; mouse_left = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      run_cycles(15, clicks, rels, taps, click_at);
      enable = 1'b1;
      run_cycles(10, clicks, rels, taps, click_at);
      checks++; if (clicks !== 0 || held !== 1'b0) begin
         errors++; $display("FAIL start_hold got clicks=%0d held=%b want 0,0", clicks, held); end
      mouse_left = 1'b0;
      run_cycles(10, clicks, rels, taps, click_at);
      checks++; if (rels !== 0) begin errors++; $display("FAIL start_release got %0d want 0", rels); end
      mouse_left = 1'b1;
      run_cycles(10, clicks, rels, taps, click_at);
      checks++; if (clicks !== 1 || held !== 1'b1) begin
         errors++; $display("FAIL start_reclick got clicks=%0d held=%b want 1,1", clicks, held); end
   endtask

   initial begin
      test_reset();
      test_click_latency();
      test_tap_release();
      test_drag();
      test_glitch_and_clamp();
      test_enable_drop();
      test_held_at_start();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
